// File: rtl/ysyx_24100006_lsu_axi_pkg.sv
`default_nettype none
// ==========================================================================
// ysyx_24100006_lsu_axi_pkg : shared encodings for the LSU AXI-Lite bridge
// Rev 1.0
// ==========================================================================
package ysyx_24100006_lsu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Size code 11 has no legal alignment, so it is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24100006_lsu_align.sv
`default_nettype none
// ==========================================================================
// ysyx_24100006_lsu_align : store lane placement and load extract/extend
// Rev 1.0
// ==========================================================================
module ysyx_24100006_lsu_align
  import ysyx_24100006_lsu_axi_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] load_shifted;
  logic        sign_bit;

  assign shamt        = {addr_lo, 3'b000};
  assign load_shifted = load_word >> shamt;
  assign bus_wdata    = store_data << shamt;

  always_comb begin
    bus_wstrb = 4'b0000;
    load_data = 32'h0000_0000;
    sign_bit  = 1'b0;
    case (size)
      SIZE_BYTE: begin
        bus_wstrb = 4'b0001 << addr_lo;
        sign_bit  = ~zero_ext & load_shifted[7];
        load_data = {{24{sign_bit}}, load_shifted[7:0]};
      end
      SIZE_HALF: begin
        bus_wstrb = 4'b0011 << addr_lo;
        sign_bit  = ~zero_ext & load_shifted[15];
        load_data = {{16{sign_bit}}, load_shifted[15:0]};
      end
      SIZE_WORD: begin
        bus_wstrb = 4'b1111;
        load_data = load_shifted;
      end
      default: begin
        bus_wstrb = 4'b0000;
        load_data = 32'h0000_0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24100006_lsu_axi.sv
`default_nettype none
// ==========================================================================
// ysyx_24100006_lsu_axi : single-outstanding LSU to AXI-Lite master bridge
// Rev 1.0
// ==========================================================================
module ysyx_24100006_lsu_axi
  import ysyx_24100006_lsu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,

  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  lsu_state_e  state;
  lsu_state_e  state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic [1:0]  resp_q;
  logic        wen_q;
  logic        zero_ext_q;
  logic        misalign_q;
  logic        aw_done;
  logic        w_done;

  logic        accept;
  logic        req_misaligned;
  logic        aw_fire;
  logic        w_fire;
  logic        bus_err;
  logic [31:0] store_bus_data;
  logic [3:0]  store_strb;
  logic [31:0] load_ext;
  logic        unused;

  // Single-beat AXI-Lite: rlast carries no information here.
  assign unused = rlast;

  assign accept         = req_valid & req_ready;
  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign aw_fire        = awvalid & awready;
  assign w_fire         = wvalid & wready;

  ysyx_24100006_lsu_align u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .zero_ext   (zero_ext_q),
    .store_data (wdata_q),
    .load_word  (rdata_q),
    .bus_wdata  (store_bus_data),
    .bus_wstrb  (store_strb),
    .load_data  (load_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_misaligned) begin
            state_next = ST_DONE;
          end else if (req_wen) begin
            state_next = ST_WADDR;
          end else begin
            state_next = ST_RADDR;
          end
        end
      end
      ST_RADDR: if (arready) state_next = ST_RDATA;
      ST_RDATA: if (rvalid)  state_next = ST_DONE;
      // AW and W may finish in either order or together.
      ST_WADDR: if ((aw_done | aw_fire) & (w_done | w_fire)) state_next = ST_WRESP;
      ST_WRESP: if (bvalid)  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      size_q     <= SIZE_BYTE;
      resp_q     <= RESP_OKAY;
      wen_q      <= 1'b0;
      zero_ext_q <= 1'b0;
      misalign_q <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        wen_q      <= req_wen;
        zero_ext_q <= req_unsigned;
        misalign_q <= req_misaligned;
        resp_q     <= RESP_OKAY;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if ((state == ST_RDATA) && rvalid) begin
        rdata_q <= rdata;
        resp_q  <= rresp;
      end
      if ((state == ST_WRESP) && bvalid) begin
        resp_q <= bresp;
      end
    end
  end

  // Any non-OKAY response is an error, EXOKAY included (CLINT-style slaves).
  always_comb begin
    bus_err = 1'b0;
    case (resp_q)
      RESP_OKAY:                             bus_err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: bus_err = 1'b1;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    araddr     = 32'h0000_0000;
    rready     = 1'b0;
    awvalid    = 1'b0;
    awaddr     = 32'h0000_0000;
    wvalid     = 1'b0;
    wdata      = 32'h0000_0000;
    wstrb      = 4'b0000;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0000_0000;
    case (state)
      // Held low while reset is asserted so all outputs read zero during reset.
      ST_IDLE:  req_ready = ~reset;
      ST_RADDR: begin
        arvalid = 1'b1;
        araddr  = addr_q;
      end
      ST_RDATA: rready = 1'b1;
      ST_WADDR: begin
        awvalid = ~aw_done;
        awaddr  = addr_q;
        wvalid  = ~w_done;
        wdata   = store_bus_data;
        wstrb   = store_strb;
      end
      ST_WRESP: bready = 1'b1;
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = misalign_q | bus_err;
        resp_rdata = (wen_q | misalign_q | bus_err) ? 32'h0000_0000 : load_ext;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_lsu_axi.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_ysyx_24100006_lsu_axi : randomized bench with a reactive AXI-Lite slave
// Rev 1.0
// ==========================================================================
module tb_ysyx_24100006_lsu_axi;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  ysyx_24100006_lsu_axi dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave configuration, written only by the stimulus side.
  int          txn_id = 0;
  int          cfg_ar_w, cfg_r_w, cfg_aw_w, cfg_w_w, cfg_b_w;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp, cfg_bresp;

  // Slave state, written only by the slave process.
  int          seen_id = 0;
  int          ar_dn, r_dn, aw_dn, w_dn, b_dn;
  bit          fire_ar, fire_r, fire_aw, fire_w, fire_b, r_pend, b_pend, b_issued;
  int          ar_beats, aw_beats, w_beats;
  bit          valid_seen;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  always @(negedge clk) begin
    if (reset || (txn_id != seen_id)) begin
      seen_id  = txn_id;
      arready  = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      fire_ar  = 0; fire_r = 0; fire_aw = 0; fire_w = 0; fire_b = 0;
      r_pend   = 0; b_pend = 0; b_issued = 0;
      ar_beats = 0; aw_beats = 0; w_beats = 0; valid_seen = 0;
      ar_dn = cfg_ar_w; aw_dn = cfg_aw_w; w_dn = cfg_w_w; r_dn = 0; b_dn = 0;
    end
    if (!reset) begin
      if (arvalid || awvalid || wvalid) valid_seen = 1;
      if (fire_ar) begin
        fire_ar = 0; arready = 1'b0; ar_beats++; r_pend = 1; r_dn = cfg_r_w;
      end else if (arvalid) begin
        if (ar_dn == 0) arready = 1'b1; else ar_dn--;
      end
      if (arvalid && arready) begin fire_ar = 1; seen_araddr = araddr; end

      if (fire_aw) begin
        fire_aw = 0; awready = 1'b0; aw_beats++;
      end else if (awvalid) begin
        if (aw_dn == 0) awready = 1'b1; else aw_dn--;
      end
      if (awvalid && awready) begin fire_aw = 1; seen_awaddr = awaddr; end

      if (fire_w) begin
        fire_w = 0; wready = 1'b0; w_beats++;
      end else if (wvalid) begin
        if (w_dn == 0) wready = 1'b1; else w_dn--;
      end
      if (wvalid && wready) begin fire_w = 1; seen_wdata = wdata; seen_wstrb = wstrb; end

      if (!b_issued && aw_beats > 0 && w_beats > 0) begin
        b_issued = 1; b_pend = 1; b_dn = cfg_b_w;
      end

      if (fire_r) begin
        fire_r = 0; rvalid = 1'b0;
      end else if (r_pend) begin
        if (r_dn == 0) begin r_pend = 0; rvalid = 1'b1; end else r_dn--;
      end
      // Off-handshake data is junk so that stray latching is visible.
      rdata = rvalid ? cfg_rdata : $urandom;
      rresp = rvalid ? cfg_rresp : 2'($urandom);
      rlast = 1'($urandom);
      if (rvalid && rready) fire_r = 1;

      if (fire_b) begin
        fire_b = 0; bvalid = 1'b0;
      end else if (b_pend) begin
        if (b_dn == 0) begin b_pend = 0; bvalid = 1'b1; end else b_dn--;
      end
      bresp = bvalid ? cfg_bresp : 2'($urandom);
      if (bvalid && bready) fire_b = 1;
    end
  end

  // Reference: pick the addressed bytes of the bus word and extend them.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input int nbytes, input bit uns);
    longint v, span;
    span = longint'(1) << (8 * nbytes);
    v = (longint'(word) >> (8 * off)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic run_access(input string tag, input bit wen, input logic [31:0] addr,
                            input logic [1:0] size, input bit uns, input logic [31:0] wd,
                            input logic [31:0] s_rdata, input logic [1:0] s_resp,
                            input int ar_w, input int r_w, input int aw_w, input int w_w,
                            input int b_w);
    int nbytes, off, n;
    bit mis, exp_err, done;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    nbytes   = 1 << size;
    off      = int'(addr[1:0]);
    mis      = (size == 2'b11) || ((off % nbytes) != 0);
    exp_err  = mis || (s_resp != 2'b00);
    exp_rd   = 32'h0;
    if (!wen && !exp_err) exp_rd = ref_load(s_rdata, off, nbytes, uns);
    exp_wd   = 32'h0;
    exp_strb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off) exp_wd[8*i +: 8] = wd[8*(i-off) +: 8];
      if (i >= off && i < off + nbytes) exp_strb[i] = 1'b1;
    end

    @(negedge clk);
    cfg_ar_w = ar_w; cfg_r_w = r_w; cfg_aw_w = aw_w; cfg_w_w = w_w; cfg_b_w = b_w;
    cfg_rdata = s_rdata; cfg_rresp = s_resp; cfg_bresp = s_resp;
    txn_id++;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    check_value($sformatf("%s ready", tag), 32'(req_ready), 32'd1);
    @(posedge clk);
    n = 0; done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin
        done = 1;
      end else begin
        // Requests offered while busy must be dropped, never queued.
        req_valid = !req_ready && ($urandom_range(0, 1) == 1);
        req_wen = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    check_value($sformatf("%s resp_seen", tag), 32'(done), 32'd1);
    if (done) begin
      check_value($sformatf("%s err", tag), 32'(resp_err), 32'(exp_err));
      check_value($sformatf("%s rdata", tag), resp_rdata, exp_rd);
      // Zero-wait: response in the fourth cycle counting the accept cycle.
      if (ar_w == 0 && r_w == 0 && aw_w == 0 && w_w == 0 && b_w == 0)
        check_value($sformatf("%s latency", tag), 32'(n), mis ? 32'd1 : 32'd3);
      if (mis) begin
        check_value($sformatf("%s no_bus", tag), 32'(valid_seen), 32'd0);
      end else if (wen) begin
        check_value($sformatf("%s beats", tag),
                    {8'd0, ar_beats[7:0], aw_beats[7:0], w_beats[7:0]}, 32'h0000_0101);
        check_value($sformatf("%s awaddr", tag), seen_awaddr, addr);
        check_value($sformatf("%s wdata", tag), seen_wdata, exp_wd);
        check_value($sformatf("%s wstrb", tag), 32'(seen_wstrb), 32'(exp_strb));
      end else begin
        check_value($sformatf("%s beats", tag),
                    {8'd0, ar_beats[7:0], aw_beats[7:0], w_beats[7:0]}, 32'h0001_0000);
        check_value($sformatf("%s araddr", tag), seen_araddr, addr);
      end
      @(negedge clk);
      check_value($sformatf("%s pulse", tag), {30'd0, resp_valid, req_ready}, 32'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_value($sformatf("%s ctl", tag),
                {21'd0, req_ready, resp_valid, resp_err, arvalid, rready, awvalid,
                 wvalid, bready, wstrb}, 32'd0);
    check_value($sformatf("%s data", tag), araddr | awaddr | wdata | resp_rdata, 32'd0);
  endtask

  task automatic reset_abort();
    bit pulse;
    @(negedge clk);
    cfg_ar_w = 0; cfg_r_w = 1000; cfg_aw_w = 0; cfg_w_w = 0; cfg_b_w = 0;
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    txn_id++;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
    check_value("abort in_rdata", {30'd0, rready, rvalid}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort during_reset");
    reset = 1'b0;
    @(negedge clk);
    check_value("abort after", {25'd0, req_ready, resp_valid, arvalid, rready, awvalid,
                                wvalid, bready}, 32'h40);
    pulse = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) pulse = 1;
    end
    check_value("abort no_resp", 32'(pulse), 32'd0);
  endtask

  initial begin
    bit          wen, uns;
    logic [1:0]  size, resp;
    logic [31:0] addr;
    int          w[5];

    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0;
    cfg_ar_w = 0; cfg_r_w = 0; cfg_aw_w = 0; cfg_w_w = 0; cfg_b_w = 0;
    cfg_rdata = 32'h0; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_value("reset ready", 32'(req_ready), 32'd1);

    run_access("ld_word",  0, 32'h0200_0004, 2'b10, 0, 32'h0, 32'h0000_0012, 2'b00, 0, 0, 0, 0, 0);
    run_access("ld_sbyte", 0, 32'h8000_0003, 2'b00, 0, 32'h0, 32'h8000_0000, 2'b00, 0, 0, 0, 0, 0);
    run_access("ld_ubyte", 0, 32'h8000_0003, 2'b00, 1, 32'h0, 32'h8000_0000, 2'b00, 0, 0, 0, 0, 0);
    run_access("st_half",  1, 32'h8000_0002, 2'b01, 0, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 3, 1);
    run_access("ld_mis",   0, 32'h8000_0001, 2'b10, 0, 32'h0, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 0, 0);
    run_access("st_exok",  1, 32'h0200_0000, 2'b10, 0, 32'hCAFE_F00D, 32'h0, 2'b01, 0, 0, 0, 0, 0);
    run_access("ld_exok",  0, 32'h0200_0000, 2'b10, 0, 32'h0, 32'hA5A5_A5A5, 2'b01, 0, 0, 0, 0, 0);
    run_access("st_zw",    1, 32'h8000_0001, 2'b00, 0, 32'h0000_0077, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    run_access("st_wfirst",1, 32'h8000_0000, 2'b10, 0, 32'h1122_3344, 32'h0, 2'b00, 2, 0, 3, 0, 2);
    run_access("ld_shalf", 0, 32'h8000_0002, 2'b01, 0, 32'h0, 32'h9abc_1234, 2'b00, 2, 3, 0, 0, 0);
    reset_abort();

    for (int t = 0; t < 60; t++) begin
      wen  = 1'($urandom);
      uns  = 1'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0 && size != 2'b11) addr[1:0] = addr[1:0] & ~2'((1 << size) - 1);
      resp = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      for (int k = 0; k < 5; k++) w[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 3);
      run_access($sformatf("rnd%0d", t), wen, addr, size, uns, $urandom, $urandom, resp,
                 w[0], w[1], w[2], w[3], w[4]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24100006_lsu_axi.md
YSYX_24100006_LSU_AXI -- requirements
Module: ysyx_24100006_lsu_axi

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits and address width at 32 bits.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  LSU access request.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_wen  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-010 req_unsigned  in  1  zero-extend a load (1) or sign-extend it (0).
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores.
REQ-014 resp_err  out  1  bus error or misaligned access.
REQ-015 AXI-Lite master ports, each 1 bit unless noted:
- araddr (32), arvalid, arready
- rvalid, rready, rdata (32), rresp (2), rlast
- awaddr (32), awvalid, awready
- wdata (32), wstrb (4), wvalid, wready
- bvalid, bready, bresp (2)

Function
REQ-016 FSM states: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
REQ-017 req_ready = 1 only in IDLE. A request is accepted on req_valid & req_ready, and the block latches addr, size, unsigned and wdata.
REQ-018 Misalignment is checked at accept and is one of:
- req_size = 11
- half access with addr[0] = 1
- word access with addr[1:0] != 0
A misaligned request starts no bus transaction. The block goes to DONE and drives resp_valid = 1 and resp_err = 1 in the next cycle.
REQ-019 Aligned load: the next cycle is RADDR with arvalid = 1 and araddr = req_addr. arvalid and araddr stay stable until arready is sampled high. The block then goes to RDATA.
REQ-020 RDATA: rready = 1. On rvalid & rready the block latches rdata and rresp and goes to DONE; rlast is ignored.
REQ-021 Aligned store: the next cycle is WADDR with the following outputs:
- awvalid = 1, awaddr = req_addr, wvalid = 1
- wdata = req_wdata shifted left by 8*addr[1:0]
- wstrb = 0001 (byte), 0011 (half) or 1111 (word), shifted left by addr[1:0]
REQ-022 In WADDR, the AW and W handshakes complete independently. awvalid drops on the cycle after its handshake and wvalid drops on the cycle after its own. The block goes to WRESP once both have completed, including when both complete in the same cycle.
REQ-023 WRESP: bready = 1. On bvalid & bready the block latches bresp and goes to DONE.
REQ-024 DONE lasts exactly one cycle: resp_valid = 1, resp_err = (latched resp != 00), then back to IDLE. Load data at DONE:
- resp_rdata = latched rdata shifted right by 8*addr[1:0], truncated to the access size and extended per req_unsigned.
- On a load error resp_rdata = 0.
REQ-025 Minimum latency from accept to resp_valid with zero-wait slaves is 4 cycles for both loads and stores. There is no timeout: the block waits indefinitely for ready, rvalid or bvalid.
REQ-026 At most one outstanding transaction. req_valid during a busy period is ignored, not queued.

Reset
REQ-027 On reset all outputs are 0: req_ready, resp_valid, resp_err, resp_rdata, every valid/ready output, araddr, awaddr, wdata and wstrb. State becomes IDLE.
REQ-028 Reset asserted mid-transaction aborts the transaction with no resp_valid. req_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package holds:
- FSM state encoding
- size codes (BYTE/HALF/WORD)
- AXI resp codes (OKAY = 00, EXOKAY = 01, SLVERR = 10, DECERR = 11)
REQ-030 One sub-module, ysyx_24100006_lsu_align, is combinational. It computes the wstrb/wdata shift and the load extract/extend, and it is instantiated once.

Verification
REQ-031 Load word at 0x0200_0004, slave returns rdata = 0x0000_0012, rresp = 00 with zero wait -> araddr = 0x0200_0004; resp_valid 4 cycles after accept; resp_rdata = 0x0000_0012, resp_err = 0.
REQ-032 Signed byte load at 0x8000_0003 with rdata = 0x8000_0000 -> resp_rdata = 0xFFFF_FF80. The same load with req_unsigned = 1 -> resp_rdata = 0x0000_0080.
REQ-033 Half store of 0x0000_BEEF at 0x8000_0002, with awready 3 cycles before wready -> wstrb = 1100, wdata = 0xBEEF_0000, a single AW and a single W beat, resp_valid after the bvalid handshake.
REQ-034 Word load at 0x8000_0001 -> no arvalid ever asserted; resp_valid with resp_err = 1 one cycle after accept.
REQ-035 Store to a slave returning bresp = 01 (CLINT-style slave) -> resp_err = 1. Load with rresp = 01 -> resp_err = 1, resp_rdata = 0.
REQ-036 Reset asserted while in RDATA with rvalid held low -> next cycle all valids are 0, no resp_valid, req_ready = 1.
